// File: rtl/memory_stage.sv
// Memory pipeline stage: EX/MEM register, data-memory handshake with wait states,
// byte-lane load/store formatting, MEM/WB register and MX/WX bypass outputs.
module memory_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       rb_out,
    input  logic [31:0]       insn,
    input  logic [5:0]        aluop,
    input  logic              dmwe,
    input  logic              rwe,
    input  logic              rdst,
    input  logic              rwd,
    input  logic              dm_byte,
    output logic              stall,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata,
    input  logic              dm_ready,
    output logic [31:0]       mx_bypass,
    output logic [4:0]        mx_rd,
    output logic              mx_rwe,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_rwe,
    output logic              misaligned
);

    localparam logic [5:0] OP_LBU = 6'b011000;
    localparam logic [5:0] OP_JAL = 6'b100000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic        m_valid_r;
    logic [31:0] m_alu_r;
    logic [31:0] m_rb_r;
    logic [4:0]  m_rd_r;
    logic        m_lbu_r;
    logic        m_dmwe_r;
    logic        m_rwe_r;
    logic        m_rwd_r;
    logic        m_byte_r;

    logic [31:0] wb_data_r;
    logic [4:0]  wb_rd_r;
    logic        wb_rwe_r;

    logic [4:0]  rd_s;
    logic        mem_s;
    logic        bad_s;
    logic        issue_s;
    logic        req_s;
    logic        stall_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] load_s;
    logic [7:0]  lane_s;
    logic        unused_s;

    // Big-endian lane select: lane 0 is the most significant byte.
    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            2'd3:    b = w[7:0];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    assign unused_s = ^{insn[31:21], insn[10:0]};

    // Destination register decode for the incoming instruction.
    always_comb begin
        rd_s = 5'd0;
        if (aluop == OP_JAL) begin
            rd_s = 5'd31;
        end else if (rdst) begin
            rd_s = insn[15:11];
        end else begin
            rd_s = insn[20:16];
        end
    end

    assign mem_s   = m_valid_r & (m_rwd_r | m_dmwe_r);
    assign bad_s   = mem_s & ~m_byte_r & (m_alu_r[1:0] != 2'b00);
    assign issue_s = mem_s & ~bad_s;
    assign req_s   = (state_r == ST_WAIT) | issue_s;
    assign stall_s = req_s & ~dm_ready;

    // Next-state logic for the memory handshake.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s && !dm_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dm_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Store formatting, byte enables and load extraction.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = m_rb_r;
        lane_s  = pick_byte(dm_rdata, m_alu_r[1:0]);
        load_s  = dm_rdata;
        if (req_s) begin
            if (m_dmwe_r && m_byte_r) begin
                be_s = 4'b1000 >> m_alu_r[1:0];
            end else begin
                be_s = 4'b1111;
            end
        end else begin
            be_s = 4'b0000;
        end
        if (m_byte_r) begin
            wdata_s = {4{m_rb_r[7:0]}};
            if (m_lbu_r) begin
                load_s = {24'h000000, lane_s};
            end else begin
                load_s = {{24{lane_s[7]}}, lane_s};
            end
        end else begin
            wdata_s = m_rb_r;
            load_s  = dm_rdata;
        end
    end

    // Handshake state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // EX/MEM register; frozen while the memory access is outstanding.
    always_ff @(posedge clock) begin
        if (reset) begin
            m_valid_r <= 1'b0;
            m_alu_r   <= 32'h0000_0000;
            m_rb_r    <= 32'h0000_0000;
            m_rd_r    <= 5'd0;
            m_lbu_r   <= 1'b0;
            m_dmwe_r  <= 1'b0;
            m_rwe_r   <= 1'b0;
            m_rwd_r   <= 1'b0;
            m_byte_r  <= 1'b0;
        end else if (!stall_s) begin
            m_valid_r <= in_valid;
            m_alu_r   <= alu_out;
            m_rb_r    <= rb_out;
            m_rd_r    <= rd_s;
            m_lbu_r   <= (aluop == OP_LBU);
            m_dmwe_r  <= dmwe;
            m_rwe_r   <= rwe;
            m_rwd_r   <= rwd;
            m_byte_r  <= dm_byte;
        end
    end

    // MEM/WB register; a stall cycle retires a bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_data_r <= 32'h0000_0000;
            wb_rd_r   <= 5'd0;
            wb_rwe_r  <= 1'b0;
        end else if (!stall_s) begin
            wb_rwe_r  <= m_valid_r & m_rwe_r & ~bad_s & (m_rd_r != 5'd0);
            wb_rd_r   <= m_rd_r;
            wb_data_r <= m_rwd_r ? load_s : m_alu_r;
        end else begin
            wb_rwe_r  <= 1'b0;
        end
    end

    assign stall      = stall_s;
    assign dm_req     = req_s;
    assign dm_we      = req_s & m_dmwe_r;
    assign dm_addr    = {m_alu_r[ADDR_W-1:2], 2'b00};
    assign dm_be      = be_s;
    assign dm_wdata   = wdata_s;
    assign misaligned = bad_s;
    assign mx_bypass  = m_alu_r;
    assign mx_rd      = m_rd_r;
    assign mx_rwe     = m_valid_r & m_rwe_r & ~m_rwd_r & (m_rd_r != 5'd0);
    assign wb_data    = wb_data_r;
    assign wb_rd      = wb_rd_r;
    assign wb_rwe     = wb_rwe_r;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, wait-state and
// reset sequences, then random traffic against a word-array memory model.
module tb_memory_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] alu_out, rb_out, insn;
    logic [5:0]  aluop;
    logic        dmwe, rwe, rdst, rwd, dm_byte;
    logic        stall, dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata, dm_rdata;
    logic        dm_ready;
    logic [31:0] mx_bypass;
    logic [4:0]  mx_rd;
    logic        mx_rwe;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_rwe, misaligned;

    int n_pass  = 0;
    int n_total = 0;

    memory_stage #(.ADDR_W(32)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .alu_out(alu_out),
        .rb_out(rb_out), .insn(insn), .aluop(aluop), .dmwe(dmwe), .rwe(rwe),
        .rdst(rdst), .rwd(rwd), .dm_byte(dm_byte), .stall(stall), .dm_req(dm_req),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready), .mx_bypass(mx_bypass),
        .mx_rd(mx_rd), .mx_rwe(mx_rwe), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_rwe(wb_rwe), .misaligned(misaligned)
    );

    always #5 clock = ~clock;

    localparam int K_ALU = 0, K_JAL = 1, K_LW = 2, K_SW = 3, K_LB = 4, K_LBU = 5, K_SB = 6;

    typedef struct {
        logic        valid;
        int          kind;
        logic [5:0]  op;
        logic [31:0] alu;
        logic [31:0] rb;
        logic [31:0] insn;
        logic        rdst;
        logic        rwe;
    } ins_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] alu;
        logic [31:0] rb;
        logic [31:0] insn;
        logic [4:0]  ctl;     // {dmwe, rwe, rdst, rwd, dm_byte}
        logic [31:0] rdata;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        logic        e_rwe;
        logic        e_req;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic        e_mis;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic is_load(input int k);
        return (k == K_LW) || (k == K_LB) || (k == K_LBU);
    endfunction
    function automatic logic is_store(input int k);
        return (k == K_SW) || (k == K_SB);
    endfunction
    function automatic logic is_byte(input int k);
        return (k == K_LB) || (k == K_LBU) || (k == K_SB);
    endfunction

    function automatic logic [4:0] f_rd(input ins_t x);
        if (x.kind == K_JAL) return 5'd31;
        return x.rdst ? x.insn[15:11] : x.insn[20:16];
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w, input int kind, input logic [1:0] k);
        logic [7:0] b;
        if (kind == K_LW) return w;
        b = 8'(w >> (8 * (3 - int'(k))));
        if (kind == K_LB) return 32'($signed(b));
        return {24'h0, b};
    endfunction

    function automatic ins_t gen();
        ins_t        x;
        logic [31:0] t;
        logic [3:0]  idx;
        logic [1:0]  off;
        x.kind  = int'($urandom_range(0, 6));
        x.valid = ($urandom_range(0, 9) != 0);
        x.insn  = $urandom;
        x.rdst  = 1'($urandom_range(0, 1));
        x.rb    = $urandom;
        x.alu   = $urandom;
        x.rwe   = 1'b1;
        case (x.kind)
            K_ALU: begin x.op = 6'($urandom_range(0, 15)); x.rwe = ($urandom_range(0, 3) != 0); end
            K_JAL: x.op = 6'b100000;
            K_LW:  x.op = 6'b010011;
            K_SW:  begin x.op = 6'b010100; x.rwe = 1'b0; end
            K_LB:  x.op = 6'b010101;
            K_LBU: x.op = 6'b011000;
            default: begin x.op = 6'b010111; x.rwe = 1'b0; end
        endcase
        if (is_load(x.kind) || is_store(x.kind)) begin
            t   = $urandom;
            idx = 4'($urandom_range(0, 15));
            if (is_byte(x.kind)) off = 2'($urandom_range(0, 3));
            else if ($urandom_range(0, 3) == 0) off = 2'($urandom_range(1, 3));
            else off = 2'b00;
            x.alu = {t[31:6], idx, off};
        end
        return x;
    endfunction

    task automatic drive(input ins_t x);
        in_valid = x.valid;
        aluop    = x.op;
        alu_out  = x.alu;
        rb_out   = x.rb;
        insn     = x.insn;
        rdst     = x.rdst;
        rwe      = x.rwe;
        dmwe     = is_store(x.kind);
        rwd      = is_load(x.kind);
        dm_byte  = is_byte(x.kind);
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; alu_out = 32'h0; rb_out = 32'h0; insn = 32'h0;
        aluop = 6'h0; dmwe = 1'b0; rwe = 1'b0; rdst = 1'b0; rwd = 1'b0; dm_byte = 1'b0;
        dm_ready = 1'b0; dm_rdata = 32'h0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v, input logic rdy);
        in_valid = 1'b1; aluop = v.op; alu_out = v.alu; rb_out = v.rb; insn = v.insn;
        {dmwe, rwe, rdst, rwd, dm_byte} = v.ctl;
        dm_ready = rdy; dm_rdata = v.rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[9];
        vec_t        v;
        ins_t        cur, nxt;
        logic [31:0] mem[16];
        int          stall_cnt;

        vt[0] = '{6'b000001, 32'h12,  32'h0,        32'h0000_1800, 5'b01100, 32'h0,
                  32'h12,        5'd3,  1'b1, 1'b0, 4'h0, 32'h0,        1'b0};
        vt[1] = '{6'b010101, 32'h101, 32'h0,        32'h0005_0000, 5'b01011, 32'h1280FF34,
                  32'hFFFFFF80,  5'd5,  1'b1, 1'b1, 4'hF, 32'h0,        1'b0};
        vt[2] = '{6'b011000, 32'h102, 32'h0,        32'h0005_0000, 5'b01011, 32'h1280FF34,
                  32'h000000FF,  5'd5,  1'b1, 1'b1, 4'hF, 32'h0,        1'b0};
        vt[3] = '{6'b010101, 32'h103, 32'h0,        32'h0005_0000, 5'b01011, 32'h1280FF34,
                  32'h00000034,  5'd5,  1'b1, 1'b1, 4'hF, 32'h0,        1'b0};
        vt[4] = '{6'b010111, 32'h203, 32'hAABBCC5A, 32'h0,         5'b10001, 32'h0,
                  32'h203,       5'd0,  1'b0, 1'b1, 4'h1, 32'h5A5A5A5A, 1'b0};
        vt[5] = '{6'b010100, 32'h202, 32'h11223344, 32'h0,         5'b10000, 32'h0,
                  32'h202,       5'd0,  1'b0, 1'b0, 4'h0, 32'h0,        1'b1};
        vt[6] = '{6'b100000, 32'h48,  32'h0,        32'h0007_0000, 5'b01000, 32'h0,
                  32'h48,        5'd31, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0};
        vt[7] = '{6'b000001, 32'h55,  32'h0,        32'h0,         5'b01100, 32'h0,
                  32'h55,        5'd0,  1'b0, 1'b0, 4'h0, 32'h0,        1'b0};
        vt[8] = '{6'b010011, 32'h100, 32'h0,        32'h0009_0000, 5'b01010, 32'hCAFEF00D,
                  32'hCAFEF00D,  5'd9,  1'b1, 1'b1, 4'hF, 32'h0,        1'b0};

        // Reset values
        do_reset();
        #1;
        chk("rst_stall", 32'(stall), 32'h0);   chk("rst_dm_req", 32'(dm_req), 32'h0);
        chk("rst_dm_we", 32'(dm_we), 32'h0);   chk("rst_dm_be", 32'(dm_be), 32'h0);
        chk("rst_dm_addr", dm_addr, 32'h0);    chk("rst_dm_wdata", dm_wdata, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);    chk("rst_wb_rd", 32'(wb_rd), 32'h0);
        chk("rst_wb_rwe", 32'(wb_rwe), 32'h0); chk("rst_mx_bypass", mx_bypass, 32'h0);
        chk("rst_mx_rd", 32'(mx_rd), 32'h0);   chk("rst_mx_rwe", 32'(mx_rwe), 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'h0);

        // Directed table, zero-wait memory
        for (int i = 0; i < 9; i++) begin
            v = vt[i];
            drive_vec(v, 1'b1);
            @(posedge clock); #2;
            in_valid = 1'b0;
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'h0);
            chk($sformatf("v%0d_req", i), 32'(dm_req), 32'(v.e_req));
            chk($sformatf("v%0d_mis", i), 32'(misaligned), 32'(v.e_mis));
            chk($sformatf("v%0d_mx_bypass", i), mx_bypass, v.alu);
            chk($sformatf("v%0d_mx_rd", i), 32'(mx_rd), 32'(v.e_rd));
            chk($sformatf("v%0d_mx_rwe", i), 32'(mx_rwe), 32'(v.ctl[3] & ~v.ctl[1] & (v.e_rd != 5'd0)));
            if (v.e_req) begin
                chk($sformatf("v%0d_be", i), 32'(dm_be), 32'(v.e_be));
                chk($sformatf("v%0d_we", i), 32'(dm_we), 32'(v.ctl[4]));
                chk($sformatf("v%0d_addr", i), dm_addr, {v.alu[31:2], 2'b00});
                if (v.ctl[4]) chk($sformatf("v%0d_wdata", i), dm_wdata, v.e_wd);
            end
            @(posedge clock); #2;
            chk($sformatf("v%0d_wb_rwe", i), 32'(wb_rwe), 32'(v.e_rwe));
            chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(v.e_rd));
            chk($sformatf("v%0d_wb_data", i), wb_data, v.e_data);
        end

        // LW with two wait cycles
        do_reset();
        v = vt[8];
        drive_vec(v, 1'b0);
        @(posedge clock); #2;
        in_valid = 1'b0;
        stall_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            dm_ready = (c == 2);
            dm_rdata = (c == 2) ? 32'hDEADBEEF : 32'h0;
            #1;
            if (stall) stall_cnt++;
            chk($sformatf("wait%0d_req", c), 32'(dm_req), 32'h1);
            chk($sformatf("wait%0d_addr", c), dm_addr, 32'h100);
            @(posedge clock); #2;
            chk($sformatf("wait%0d_wb_rwe", c), 32'(wb_rwe), 32'(c == 2));
        end
        chk("wait_stall_cycles", 32'(stall_cnt), 32'd2);
        chk("wait_wb_data", wb_data, 32'hDEADBEEF);
        chk("wait_wb_rd", 32'(wb_rd), 32'd9);

        // Reset while the load is waiting
        dm_ready = 1'b0;
        drive_vec(v, 1'b0);
        @(posedge clock); #2;
        in_valid = 1'b0;
        #1 chk("rw_stall_before", 32'(stall), 32'h1);
        @(posedge clock); #2;
        reset = 1'b1;
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        chk("rw_req", 32'(dm_req), 32'h0);
        chk("rw_stall", 32'(stall), 32'h0);
        chk("rw_wb_rwe", 32'(wb_rwe), 32'h0);
        dm_ready = 1'b1;
        dm_rdata = 32'h0BAD0BAD;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("rw_late%0d_req", c), 32'(dm_req), 32'h0);
            chk($sformatf("rw_late%0d_stall", c), 32'(stall), 32'h0);
            @(posedge clock); #2;
            chk($sformatf("rw_late%0d_wb_rwe", c), 32'(wb_rwe), 32'h0);
        end

        // Random traffic against a word-array memory
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        do_reset();
        cur = '{1'b0, K_ALU, 6'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        for (int c = 0; c < 400; c++) begin
            logic       rdy, mem_op, bad, e_req, e_stall, e_rwe;
            logic [1:0] k;
            logic [3:0] idx;
            logic [31:0] e_data;
            int         sh;
            rdy = ($urandom_range(0, 2) != 0);
            nxt = gen();
            drive(nxt);
            dm_ready = rdy;
            k      = cur.alu[1:0];
            idx    = cur.alu[5:2];
            mem_op = cur.valid & (is_load(cur.kind) | is_store(cur.kind));
            bad    = mem_op & ~is_byte(cur.kind) & (k != 2'b00);
            e_req  = mem_op & ~bad;
            dm_rdata = e_req ? mem[idx] : $urandom;
            #1;
            e_stall = e_req & ~rdy;
            chk("rnd_req", 32'(dm_req), 32'(e_req));
            chk("rnd_stall", 32'(stall), 32'(e_stall));
            chk("rnd_mis", 32'(misaligned), 32'(bad));
            if (e_req) begin
                chk("rnd_addr", dm_addr, {cur.alu[31:2], 2'b00});
                chk("rnd_we", 32'(dm_we), 32'(is_store(cur.kind)));
                chk("rnd_be", 32'(dm_be),
                    (cur.kind == K_SB) ? 32'(1 << (3 - int'(k))) : 32'hF);
                if (is_store(cur.kind))
                    chk("rnd_wdata", dm_wdata, (cur.kind == K_SB) ? {4{cur.rb[7:0]}} : cur.rb);
            end
            e_rwe  = cur.valid & cur.rwe & ~bad & (f_rd(cur) != 5'd0);
            e_data = is_load(cur.kind) ? load_val(mem[idx], cur.kind, k) : cur.alu;
            if (!e_stall && e_req && is_store(cur.kind)) begin
                if (cur.kind == K_SW) mem[idx] = cur.rb;
                else begin
                    sh = 8 * (3 - int'(k));
                    mem[idx] = (mem[idx] & ~(32'hFF << sh)) | ({24'h0, cur.rb[7:0]} << sh);
                end
            end
            @(posedge clock); #2;
            if (e_stall) begin
                chk("rnd_bubble", 32'(wb_rwe), 32'h0);
            end else begin
                chk("rnd_wb_rwe", 32'(wb_rwe), 32'(e_rwe));
                chk("rnd_wb_rd", 32'(wb_rd), 32'(f_rd(cur)));
                if (!is_load(cur.kind) || e_req) chk("rnd_wb_data", wb_data, e_data);
                cur = nxt;
            end
            chk("rnd_mx_bypass", mx_bypass, cur.alu);
            chk("rnd_mx_rd", 32'(mx_rd), 32'(f_rd(cur)));
            chk("rnd_mx_rwe", 32'(mx_rwe),
                32'(cur.valid & cur.rwe & ~is_load(cur.kind) & (f_rd(cur) != 5'd0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline stage directly downstream of the execute stage. It registers the execute results (ALU result, store data, instruction, control) into an EX/MEM register and runs load/store traffic against data memory through a req/ready handshake. Byte accesses are aligned big-endian; LB results are sign-extended and LBU results zero-extended. It produces the MEM/WB register and the MX/WX bypass values, and stalls upstream while a memory access waits.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width (low ADDR_W bits of the ALU result are used)

Ports:
- clock  in  1  stage clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- in_valid  in  1  execute stage presents a valid instruction
- alu_out  in  32  execute ALU result (memory address for loads/stores)
- rb_out  in  32  execute rB after bypass (store data)
- insn  in  32  instruction word
- aluop  in  6  execute aluop code (LW 010011, SW 010100, LB 010101, SB 010111, LBU 011000, JAL 100000)
- dmwe, rwe, rdst, rwd, dm_byte  in  1 each  execute control: store, register write, rd-vs-rt select, load-result select, byte access
- stall  out  1  hold the upstream stages; combinational
- dm_req  out  1  memory request
- dm_we  out  1  write strobe; valid with dm_req
- dm_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- dm_be  out  4  byte enables; bit 3 = bits 31:24
- dm_wdata  out  32  store data
- dm_rdata  in  32  read data; valid when dm_ready
- dm_ready  in  1  access completes this cycle
- mx_bypass  out  32  EX/MEM ALU result, for MX forwarding
- mx_rd  out  5  EX/MEM destination register
- mx_rwe  out  1  EX/MEM valid & rwe & not a load
- wb_data  out  32  MEM/WB write value (also the WX bypass value)
- wb_rd  out  5  MEM/WB destination register
- wb_rwe  out  1  MEM/WB register write enable
- misaligned  out  1  one-cycle pulse: word access with addr[1:0]≠0 was dropped

## Operation
- EX/MEM register (m_*): loads in_valid and all inputs when stall=0; holds when stall=1.
- Destination: aluop=JAL → 31; otherwise rdst=1 → insn[15:11], rdst=0 → insn[20:16]. Register 0 is never written (mx_rwe and wb_rwe are forced 0).
- m_mem = m_valid & (m_rwd | m_dmwe). m_word_bad = m_mem & ~m_dm_byte & (m_addr[1:0]≠0).
- FSM with states IDLE and WAIT:
  - IDLE, m_mem & ~m_word_bad: dm_req=1. dm_ready=1 completes the access in the same cycle; dm_ready=0 goes to WAIT.
  - WAIT: dm_req=1 with address, be and wdata held constant. dm_ready=1 → IDLE.
  - m_word_bad: no request is issued; misaligned pulses for one cycle, and the instruction retires with wb_rwe=0.
- stall = (state==WAIT | (m_mem & ~m_word_bad)) & ~dm_ready.
- Stores: dm_we=1. SW: be=1111, wdata=rb. SB: be=4'b1000>>addr[1:0], wdata={4{rb[7:0]}}.
- Loads: dm_we=0, be=1111. Byte lane k=addr[1:0] selects dm_rdata[31-8k -: 8]. LB sign-extends the byte; LBU zero-extends it.
- MEM/WB register: when stall=0, wb_rwe ← m_valid & m_rwe & ~m_word_bad & rd≠0. wb_data ← load result if m_rwd, else m_alu. When stall=1, wb_rwe ← 0 (bubble) and wb_data/wb_rd hold.

## Timing
- Reset values:
  - all m_* registers 0; state IDLE
  - dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0
  - wb_data=0, wb_rd=0, wb_rwe=0
  - mx_bypass=0, mx_rd=0, mx_rwe=0
  - misaligned=0, stall=0
- Reset asserted during WAIT: the FSM returns to IDLE and the in-flight instruction is discarded. dm_req is low in the cycle after the reset edge. A dm_ready arriving after reset is ignored.
- Latency:
  - zero-wait access: EX→wb_* takes 2 edges (EX/MEM edge, then MEM/WB edge)
  - each cycle with dm_ready=0 adds one stall cycle and one WB bubble
- Non-memory instructions never stall.
- Back-to-back memory ops: the next op is captured on the edge where the current one completes, and its request begins the following cycle.
- dm_ready while dm_req=0 has no effect.
- mx_* outputs are driven directly from the EX/MEM registers (no combinational path from inputs). wb_* outputs are driven directly from the MEM/WB registers.

## Test plan
- ADD: alu_out=0x12, rwe=1, rd=3, dm_ready tied 1 → mx_bypass=0x12 one edge later; wb_data=0x12, wb_rd=3, wb_rwe=1 two edges later; stall never asserted.
- LW: addr 0x100, dm_ready low 2 cycles, dm_rdata=0xDEADBEEF → stall high exactly 2 cycles, dm_addr stable at 0x100, 2 WB bubbles, then wb_data=0xDEADBEEF.
- LB vs LBU: dm_rdata=0x1280FF34. LB at addr 0x...1 → 0xFFFFFF80. LBU at addr 0x...2 → 0x000000FF. LB at addr 0x...3 → 0x00000034.
- SB: addr 0x203, rb=0xAABBCC5A → dm_be=0001, dm_wdata=0x5A5A5A5A, dm_we=1, wb_rwe=0. SW at 0x202 → no dm_req, misaligned pulses for 1 cycle.
- Reset during WAIT of LW → next cycle dm_req=0, wb_rwe=0, stall=0. A later dm_ready=1 changes nothing.
- JAL: alu_out=pc+8=0x48, rdst=0 → wb_rd=31, wb_data=0x48. Instruction with rd=0 → wb_rwe=0.
